// File: rtl/cart_loader_if.sv
// Bundle of the HPS ioctl download stream, the cartridge RAM ports and the loader status.
// master = the loader, slave = the environment that feeds bytes and owns the RAM.
interface cart_loader_if #(
  parameter int AW = 16
);
  logic          ioctl_download;
  logic          ioctl_wr;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout;
  logic [AW-1:0] ram_wraddress;
  logic [7:0]    ram_data;
  logic          ram_wren;
  logic [AW-1:0] ram_rdaddress;
  logic [7:0]    ram_q;
  logic [AW:0]   rom_size;
  logic [AW-1:0] rom_mask;
  logic          overflow;
  logic          busy;
  logic          done;
  logic          cart_reset;

  modport master (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ram_q,
    output ram_wraddress, ram_data, ram_wren, ram_rdaddress,
    output rom_size, rom_mask, overflow, busy, done, cart_reset
  );

  modport slave (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ram_q,
    input  ram_wraddress, ram_data, ram_wren, ram_rdaddress,
    input  rom_size, rom_mask, overflow, busy, done, cart_reset
  );
endinterface

// File: rtl/cart_loader.sv
// Writes the ioctl ROM download into cartridge RAM (1-cycle registered write), then pads/mirrors it up to MIN_SIZE.
// No backpressure: every strobe is taken; post-fill runs at 1 byte/cycle (pad) or 2 cycles/byte (mirror).
module cart_loader #(
  parameter int         AW       = 16,
  parameter int         MIN_SIZE = 4096,
  parameter logic [7:0] PAD_BYTE = 8'hFF
) (
  input  logic          clock,
  input  logic          reset,
  cart_loader_if.master bus
);

  typedef enum logic [2:0] {IDLE, LOAD, PAD, MIR_RD, MIR_WR, DONE} state_t;

  localparam logic [AW:0] MIN_W = (AW+1)'(MIN_SIZE);

  state_t        state_q, state_d;
  logic          dl_q;
  logic [AW:0]   rom_size_q, rom_size_d;
  logic [AW:0]   dst_q, dst_d;
  logic [AW:0]   p2_q, p2_d;
  logic [AW-1:0] rom_mask_q, rom_mask_d;
  logic          overflow_q, overflow_d;
  logic          wr_pend_q, wr_pend_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;

  logic          dl_rise, dl_fall, in_range, strobe_ok;
  logic [AW:0]   addr_p1, size_upd, p2_new, p2m1;
  logic          fill_wren;
  logic [AW-1:0] fill_addr, rd_addr;
  logic [7:0]    fill_data;

  function automatic logic [AW:0] next_pow2(input logic [AW:0] n);
    logic [AW:0] p;
    logic        found;
    p     = (AW+1)'(1);
    found = 1'b0;
    for (int i = 0; i <= AW; i++) begin
      if (!found && (((AW+1)'(1) << i) >= n)) begin
        p     = (AW+1)'(1) << i;
        found = 1'b1;
      end
    end
    return p;
  endfunction

  function automatic logic [AW-1:0] mask_of(input logic [AW:0] p);
    return AW'(((p > MIN_W) ? p : MIN_W) - (AW+1)'(1));
  endfunction

  assign dl_rise   = bus.ioctl_download & ~dl_q;
  assign dl_fall   = ~bus.ioctl_download & dl_q;
  assign in_range  = (bus.ioctl_addr[24:AW] == '0);
  assign addr_p1   = {1'b0, bus.ioctl_addr[AW-1:0]} + (AW+1)'(1);
  assign strobe_ok = (state_q == LOAD) && bus.ioctl_wr && in_range;
  // A strobe in the falling-edge cycle must count towards the size used for the post-fill plan.
  assign size_upd  = (strobe_ok && (addr_p1 > rom_size_q)) ? addr_p1 : rom_size_q;
  assign p2_new    = next_pow2(size_upd);
  assign p2m1      = p2_q - (AW+1)'(1);

  always_comb begin
    state_d    = state_q;
    rom_size_d = rom_size_q;
    dst_d      = dst_q;
    p2_d       = p2_q;
    rom_mask_d = rom_mask_q;
    overflow_d = overflow_q;
    wr_pend_d  = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    fill_wren  = 1'b0;
    fill_addr  = '0;
    fill_data  = '0;
    rd_addr    = '0;

    if (dl_rise && (state_q != LOAD)) begin
      // New download wins over everything, including an unfinished post-fill.
      state_d    = LOAD;
      rom_size_d = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (bus.ioctl_wr) begin
            if (in_range) begin
              wr_pend_d  = 1'b1;
              wr_addr_d  = bus.ioctl_addr[AW-1:0];
              wr_data_d  = bus.ioctl_dout;
              rom_size_d = size_upd;
            end else begin
              overflow_d = 1'b1;
            end
          end
          if (dl_fall) begin
            p2_d = p2_new;
            if (size_upd == '0) begin
              state_d    = DONE;
              rom_mask_d = AW'(MIN_SIZE - 1);
            end else if (p2_new > size_upd) begin
              state_d = PAD;
              dst_d   = size_upd;
            end else if (p2_new < MIN_W) begin
              state_d = MIR_RD;
              dst_d   = p2_new;
            end else begin
              state_d    = DONE;
              rom_mask_d = mask_of(p2_new);
            end
          end
        end
        PAD: begin
          // Yield the write port to a byte still in flight from the last LOAD cycle.
          if (!wr_pend_q) begin
            fill_wren = 1'b1;
            fill_addr = dst_q[AW-1:0];
            fill_data = PAD_BYTE;
            dst_d     = dst_q + (AW+1)'(1);
            if (dst_q == p2m1) begin
              if (p2_q < MIN_W) begin
                state_d = MIR_RD;
              end else begin
                state_d    = DONE;
                rom_mask_d = mask_of(p2_q);
              end
            end
          end
        end
        MIR_RD: begin
          rd_addr = AW'(dst_q & p2m1);
          state_d = MIR_WR;
        end
        MIR_WR: begin
          fill_wren = 1'b1;
          fill_addr = dst_q[AW-1:0];
          fill_data = bus.ram_q;
          if (dst_q == MIN_W - (AW+1)'(1)) begin
            state_d    = DONE;
            rom_mask_d = mask_of(p2_q);
          end else begin
            dst_d   = dst_q + (AW+1)'(1);
            state_d = MIR_RD;
          end
        end
        IDLE, DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      dl_q       <= 1'b0;
      rom_size_q <= '0;
      dst_q      <= '0;
      p2_q       <= '0;
      rom_mask_q <= AW'(MIN_SIZE - 1);
      overflow_q <= 1'b0;
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      dl_q       <= bus.ioctl_download;
      rom_size_q <= rom_size_d;
      dst_q      <= dst_d;
      p2_q       <= p2_d;
      rom_mask_q <= rom_mask_d;
      overflow_q <= overflow_d;
      wr_pend_q  <= wr_pend_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.ram_wren      = wr_pend_q | fill_wren;
  assign bus.ram_wraddress = wr_pend_q ? wr_addr_q : fill_addr;
  assign bus.ram_data      = wr_pend_q ? wr_data_q : fill_data;
  assign bus.ram_rdaddress = rd_addr;
  assign bus.rom_size      = rom_size_q;
  assign bus.rom_mask      = rom_mask_q;
  assign bus.overflow      = overflow_q;
  assign bus.busy          = (state_q == PAD) || (state_q == MIR_RD) || (state_q == MIR_WR);
  assign bus.done          = (state_q == DONE);
  assign bus.cart_reset    = bus.ioctl_download | bus.busy | reset;

endmodule

// File: tb/tb_cart_loader.sv
// Bench for cart_loader: table of image sizes with hand-computed results, plus directed corner sequences.
module tb_cart_loader;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  cart_loader_if #(.AW(16)) bus();

  cart_loader #(.AW(16), .MIN_SIZE(4096), .PAD_BYTE(8'hFF)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Cartridge RAM: registered read, q valid the cycle after the address.
  logic [7:0] mem [0:65535];
  always @(posedge clock) begin
    if (bus.ram_wren) mem[bus.ram_wraddress] <= bus.ram_data;
    bus.ram_q <= mem[bus.ram_rdaddress];
  end

  int total = 0;
  int bad   = 0;
  int done_wr = 0;
  always @(negedge clock) if (bus.done && bus.ram_wren) done_wr++;

  typedef struct {
    int          n;
    bit          sparse;
    logic [16:0] size;
    logic [15:0] mask;
    int          busy;
    int          p2;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] pat(input int a);
    logic [31:0] t;
    t = a;
    return t[7:0] ^ 8'h5A;
  endfunction

  task automatic mem_fill();
    for (int i = 0; i < 65536; i++) mem[i] = 8'hA5;
  endtask

  task automatic strobe(input int a, input logic [7:0] d);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = 25'(a);
    bus.ioctl_dout = d;
    tick();
    bus.ioctl_wr   = 1'b0;
  endtask

  // Leaves ioctl_download low but not yet clocked, so the next edge is the falling-edge edge.
  task automatic load(input int n, input bit sparse);
    bus.ioctl_download = 1'b1;
    tick();
    for (int a = 0; a < n; a++)
      if (!sparse || a < 16 || a == n - 1) strobe(a, pat(a));
    bus.ioctl_download = 1'b0;
  endtask

  task automatic wait_done(input string name, output int busy_cyc, output int lat);
    busy_cyc = 0;
    lat      = 0;
    for (int c = 0; c < 20000; c++) begin
      tick();
      lat++;
      if (bus.busy) busy_cyc++;
      if (bus.done) break;
    end
    check({name, "_done_reached"}, 32'(bus.done), 32'd1);
  endtask

  task automatic ram_check(input string name, input int n, input int p2);
    int errs;
    logic [7:0] exp;
    int j;
    errs = 0;
    for (int i = 0; i < 4096; i++) begin
      j   = i & (p2 - 1);
      exp = (j < n) ? pat(j) : 8'hFF;
      if (mem[i] !== exp) begin
        if (errs == 0) $display("ram %s first bad addr %0h got %0h want %0h", name, i, mem[i], exp);
        errs++;
      end
    end
    check({name, "_ram_bad_bytes"}, 32'(errs), 32'd0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, lat, found, wcnt;

    vecs[0] = '{2048,  1'b0, 17'h00800, 16'h0FFF, 4096, 2048};
    vecs[1] = '{3000,  1'b0, 17'h00BB8, 16'h0FFF, 1096, 4096};
    vecs[2] = '{1500,  1'b0, 17'h005DC, 16'h0FFF, 4644, 2048};
    vecs[3] = '{1,     1'b0, 17'h00001, 16'h0FFF, 8190, 1};
    vecs[4] = '{4096,  1'b1, 17'h01000, 16'h0FFF, 0,    4096};
    vecs[5] = '{8192,  1'b1, 17'h02000, 16'h1FFF, 0,    8192};
    vecs[6] = '{65536, 1'b1, 17'h10000, 16'hFFFF, 0,    65536};

    reset              = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;
    tick();
    tick();
    check("rst_cart_reset", 32'(bus.cart_reset), 32'd1);
    check("rst_rom_mask",   32'(bus.rom_mask),   32'h0FFF);
    check("rst_rom_size",   32'(bus.rom_size),   32'd0);
    check("rst_done",       32'(bus.done),       32'd0);
    check("rst_busy",       32'(bus.busy),       32'd0);
    check("rst_wren",       32'(bus.ram_wren),   32'd0);
    check("rst_overflow",   32'(bus.overflow),   32'd0);
    reset = 1'b0;
    tick();
    check("idle_cart_reset", 32'(bus.cart_reset), 32'd0);

    for (int v = 0; v < 7; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      mem_fill();
      load(vecs[v].n, vecs[v].sparse);
      wait_done(nm, bc, lat);
      check({nm, "_rom_size"},   32'(bus.rom_size),   32'(vecs[v].size));
      check({nm, "_rom_mask"},   32'(bus.rom_mask),   32'(vecs[v].mask));
      check({nm, "_busy_cyc"},   32'(bc),             32'(vecs[v].busy));
      check({nm, "_done_lat"},   32'(lat),            32'(vecs[v].busy + 1));
      check({nm, "_overflow"},   32'(bus.overflow),   32'd0);
      check({nm, "_cart_reset"}, 32'(bus.cart_reset), 32'd0);
      if (!vecs[v].sparse) ram_check(nm, vecs[v].n, vecs[v].p2);
    end

    // Out-of-range strobe: dropped, sticky overflow, size untouched; next download clears it.
    bus.ioctl_download = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) strobe(a, pat(a));
    strobe(4095, pat(4095));
    strobe(32'h10000, 8'h77);
    check("ovf_no_wren",  32'(bus.ram_wren), 32'd0);
    check("ovf_sticky",   32'(bus.overflow), 32'd1);
    bus.ioctl_download = 1'b0;
    wait_done("ovf", bc, lat);
    check("ovf_rom_size", 32'(bus.rom_size), 32'h1000);
    check("ovf_kept",     32'(bus.overflow), 32'd1);
    bus.ioctl_download = 1'b1;
    tick();
    check("ovf_cleared",  32'(bus.overflow), 32'd0);
    check("redl_done",    32'(bus.done),     32'd0);
    bus.ioctl_download = 1'b0;
    wait_done("empty", bc, lat);
    check("empty_rom_size", 32'(bus.rom_size), 32'd0);
    check("empty_rom_mask", 32'(bus.rom_mask), 32'h0FFF);
    check("empty_lat",      32'(lat),          32'd1);

    // Strobe in the falling-edge cycle is written and sized in.
    mem_fill();
    bus.ioctl_download = 1'b1;
    tick();
    for (int a = 0; a < 3; a++) strobe(a, pat(a));
    bus.ioctl_download = 1'b0;
    strobe(3, pat(3));
    check("fall_wr_wren", 32'(bus.ram_wren),      32'd1);
    check("fall_wr_addr", 32'(bus.ram_wraddress), 32'd3);
    wait_done("fall", bc, lat);
    check("fall_rom_size", 32'(bus.rom_size), 32'd4);
    check("fall_rom_mask", 32'(bus.rom_mask), 32'h0FFF);
    ram_check("fall", 4, 4);

    // Reset in the middle of a mirror write.
    load(16, 1'b0);
    found = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (bus.ram_wren && bus.busy) begin
        found = 1;
        break;
      end
    end
    check("mirwr_reached", 32'(found), 32'd1);
    reset = 1'b1;
    tick();
    check("rst_mir_wren",       32'(bus.ram_wren),   32'd0);
    check("rst_mir_busy",       32'(bus.busy),       32'd0);
    check("rst_mir_cart_reset", 32'(bus.cart_reset), 32'd1);
    reset = 1'b0;
    tick();
    check("rst_mir_idle_done", 32'(bus.done), 32'd0);

    // New download while padding aborts the post-fill.
    load(3000, 1'b1);
    for (int c = 0; c < 50; c++) tick();
    check("abort_in_pad", 32'(bus.busy), 32'd1);
    bus.ioctl_download = 1'b1;
    #1;
    check("abort_rise_wren", 32'(bus.ram_wren), 32'd0);
    tick();
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    wcnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.ram_wren) wcnt++;
      tick();
    end
    check("abort_no_writes", 32'(wcnt), 32'd0);
    bus.ioctl_download = 1'b0;
    wait_done("abort", bc, lat);
    check("abort_final_lat", 32'(lat), 32'd1);

    check("no_wren_in_done", 32'(done_wr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
